// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
package arb_mux_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int WIDTH_DEF  = 8;

    // A single channel index bit is kept even for degenerate channel counts.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin grant: first requester after last_grant, cyclically.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_grant) + i) % NUM_CH;
            if (enable && !grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 round-robin arbiter with a single registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    parameter  int WIDTH  = WIDTH_DEF,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CH-1:0]       in_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] in_data_i,
    output logic [NUM_CH-1:0]       in_ready_o,
    output logic                    out_valid_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [CH_W-1:0]         out_ch_o,
    input  logic                    out_ready_i
);

    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] grant_idx;
    logic            grant_valid;
    logic            load_en;

    // Reset gates the arbiter so no beat is offered while reset is held.
    assign load_en = (!out_valid_o || out_ready_i) && !reset_i;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req         (in_valid_i),
        .last_grant  (last_grant),
        .enable      (load_en),
        .grant       (in_ready_o),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            last_grant  <= CH_W'(NUM_CH - 1);
        end else if (grant_valid) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch_o    <= grant_idx;
            last_grant  <= grant_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: directed scenarios then randomized traffic.
module tb_arb_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic [N-1:0] in_valid_i = '0;
    logic [N*W-1:0] in_data_i = '0;
    logic [N-1:0] in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] out_data_o;
    logic [1:0]   out_ch_o;
    logic         out_ready_i = 1'b0;

    arb_mux #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ch_o    (out_ch_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] sb[$];

    // Reference state: what the output register and arbitration pointer
    // must hold after each edge.
    bit         armed = 0;
    bit         mv = 0;
    logic [7:0] md = '0;
    logic [1:0] mc = '0;
    int         last = N - 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] d,
                        input logic ordy, input logic rst);
        int g;
        logic [3:0] exp_rdy;
        @(negedge clk_i);
        #2;
        if (armed) begin
            chk("out_valid", 32'(out_valid_o), 32'(mv));
            chk("out_data", 32'(out_data_o), 32'(md));
            chk("out_ch", 32'(out_ch_o), 32'(mc));
        end
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        reset_i     = rst;
        g = -1;
        if (!rst && (!mv || ordy)) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (last + i) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        #1;
        if (armed) chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
        if (rst) begin
            mv = 0; md = '0; mc = '0; last = N - 1;
            armed = 1;
        end else if (g >= 0) begin
            mv = 1; md = d[g*W +: W]; mc = 2'(g); last = g;
            sb.push_back({mc, md});
        end else if (ordy) begin
            mv = 0;
        end
    endtask

    // Monitor: every presented beat must match the oldest accepted beat.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (out_valid_o === 1'b1) begin
                if (sb.size() == 0)
                    chk("sb_extra", 32'(out_valid_o), 32'd0);
                else
                    chk("sb_beat", 32'({out_ch_o, out_data_o}), 32'(sb[0]));
            end else if (sb.size() != 0) begin
                chk("sb_missing", 32'(out_valid_o), 32'd1);
            end
            #2;
            if (reset_i)
                sb.delete();
            else if (out_valid_o === 1'b1 && out_ready_i && sb.size() != 0)
                void'(sb.pop_front());
        end
    end

    initial begin
        // Reset held with all channels requesting.
        repeat (3) step(4'b1111, 32'h1312_1110, 1'b1, 1'b1);
        // Round-robin across all channels.
        repeat (5) step(4'b1111, 32'h1312_1110, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b1, 1'b0);
        // Backpressure on a single beat from channel 2.
        step(4'b0100, 32'h00A5_0000, 1'b1, 1'b0);
        repeat (5) step(4'b1111, 32'h5555_5555, 1'b0, 1'b0);
        step(4'b0000, 32'h0, 1'b1, 1'b0);
        // Wrap and skip after channel 3.
        step(4'b1000, 32'h4400_0000, 1'b1, 1'b0);
        repeat (3) step(4'b1010, 32'h3300_2200, 1'b1, 1'b0);
        step(4'b0000, 32'h0, 1'b1, 1'b0);
        // Drain of a lone beat.
        step(4'b0001, 32'h0000_003C, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 32'h0, 1'b1, 1'b0);
        // Reset while a beat is stalled.
        step(4'b0001, 32'h0000_0077, 1'b0, 1'b0);
        step(4'b0000, 32'h0, 1'b0, 1'b0);
        step(4'b1001, 32'hEE00_00DD, 1'b0, 1'b1);
        repeat (3) step(4'b1001, 32'hEE00_00DD, 1'b1, 1'b0);
        // Randomized traffic.
        for (int t = 0; t < 2000; t++) begin
            step(4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        end
        repeat (4) step(4'b0000, 32'h0, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
